// File: rtl/dcpu_pkg.sv
// Shared encodings for the DCPU-16 operand fetch slice: FSM states, destination
// kinds, special-register indices and the 6-bit operand field landmarks.
package dcpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A_DEC = 3'd1,
        S_A_NW  = 3'd2,
        S_A_LD  = 3'd3,
        S_B_DEC = 3'd4,
        S_B_NW  = 3'd5,
        S_B_LD  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [1:0] DST_NONE    = 2'd0;
    localparam logic [1:0] DST_REG     = 2'd1;
    localparam logic [1:0] DST_MEM     = 2'd2;
    localparam logic [1:0] DST_SPECIAL = 2'd3;

    localparam logic [2:0] IDX_SP = 3'd0;
    localparam logic [2:0] IDX_PC = 3'd1;
    localparam logic [2:0] IDX_O  = 3'd2;

    localparam logic [5:0] F_REG_LO   = 6'h00;
    localparam logic [5:0] F_IND_LO   = 6'h08;
    localparam logic [5:0] F_NWREG_LO = 6'h10;
    localparam logic [5:0] F_POP      = 6'h18;
    localparam logic [5:0] F_PEEK     = 6'h19;
    localparam logic [5:0] F_PUSH     = 6'h1a;
    localparam logic [5:0] F_SP       = 6'h1b;
    localparam logic [5:0] F_PC       = 6'h1c;
    localparam logic [5:0] F_O        = 6'h1d;
    localparam logic [5:0] F_IND_NW   = 6'h1e;
    localparam logic [5:0] F_NW_LIT   = 6'h1f;
    localparam logic [5:0] F_LIT_BASE = 6'h20;

    function automatic logic [2:0] special_idx(input logic [5:0] field);
        case (field)
            F_SP:    special_idx = IDX_SP;
            F_PC:    special_idx = IDX_PC;
            F_O:     special_idx = IDX_O;
            default: special_idx = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dcpu_operand_classify.sv
// Combinational classification of one 6-bit operand field into the resolution
// steps it needs and the destination kind it names.
module dcpu_operand_classify
    import dcpu_pkg::*;
(
    input  logic [5:0] field,
    output logic       needs_nw,
    output logic       needs_ld,
    output logic       uses_reg,
    output logic       sp_predec,
    output logic       sp_postinc,
    output logic       is_literal,
    output logic [1:0] dst_kind
);

    always_comb begin
        needs_nw   = 1'b0;
        needs_ld   = 1'b0;
        uses_reg   = 1'b0;
        sp_predec  = 1'b0;
        sp_postinc = 1'b0;
        is_literal = 1'b0;
        dst_kind   = DST_NONE;
        if (field >= F_LIT_BASE) begin
            is_literal = 1'b1;
        end else if (field < F_IND_LO) begin
            uses_reg = 1'b1;
            dst_kind = DST_REG;
        end else if (field < F_NWREG_LO) begin
            uses_reg = 1'b1;
            needs_ld = 1'b1;
            dst_kind = DST_MEM;
        end else if (field < F_POP) begin
            uses_reg = 1'b1;
            needs_nw = 1'b1;
            needs_ld = 1'b1;
            dst_kind = DST_MEM;
        end else begin
            case (field)
                F_POP: begin
                    needs_ld   = 1'b1;
                    sp_postinc = 1'b1;
                    dst_kind   = DST_MEM;
                end
                F_PEEK: begin
                    needs_ld = 1'b1;
                    dst_kind = DST_MEM;
                end
                F_PUSH: begin
                    needs_ld  = 1'b1;
                    sp_predec = 1'b1;
                    dst_kind  = DST_MEM;
                end
                F_SP, F_PC, F_O: dst_kind = DST_SPECIAL;
                F_IND_NW: begin
                    needs_nw = 1'b1;
                    needs_ld = 1'b1;
                    dst_kind = DST_MEM;
                end
                F_NW_LIT: begin
                    needs_nw   = 1'b1;
                    is_literal = 1'b1;
                end
                default: dst_kind = DST_NONE;
            endcase
        end
    end

endmodule

// File: rtl/dcpu_operand_fetch.sv
// DCPU-16 operand resolution stage: resolves operand a then b (or only the b
// field for special opcodes), applying PC/SP side effects in that order.
module dcpu_operand_fetch
    import dcpu_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] ir,
    input  logic [AWIDTH-2:0] pc_in,
    input  logic [AWIDTH-2:0] sp_in,
    input  logic [DWIDTH-1:0] o_in,
    output logic [2:0]        reg_sel,
    input  logic [DWIDTH-1:0] reg_rdata,
    output logic              mem_re,
    output logic [AWIDTH-2:0] memaddr,
    input  logic [DWIDTH-1:0] rmemdata,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] a_val,
    output logic [DWIDTH-1:0] b_val,
    output logic [1:0]        a_dst,
    output logic [2:0]        a_idx,
    output logic [AWIDTH-2:0] a_addr,
    output logic [AWIDTH-2:0] pc_out,
    output logic [AWIDTH-2:0] sp_out,
    output logic              special,
    output state_t            state
);

    localparam int AW1 = AWIDTH - 1;
    localparam logic [AW1-1:0] ADDR_ONE = AW1'(1);

    state_t              state_q, state_d;
    logic [11:0]         fields_q, fields_d;
    logic [AW1-1:0]      pc_q, pc_d, sp_q, sp_d;
    logic [DWIDTH-1:0]   o_q, o_d;
    logic [DWIDTH-1:0]   a_val_d, b_val_d, val;
    logic [1:0]          a_dst_d;
    logic [2:0]          a_idx_d;
    logic [AW1-1:0]      a_addr_d;
    logic                special_d, val_en, addr_en, is_a;
    logic [5:0]          field;
    state_t              phase_end;

    logic       needs_nw, needs_ld, uses_reg, sp_predec, sp_postinc, is_literal;
    logic [1:0] dst_kind;

    // Special opcodes carry their single operand in the b field but report it on a.
    assign is_a      = (state_q == S_A_DEC) || (state_q == S_A_NW) || (state_q == S_A_LD);
    assign field     = (is_a && !special) ? fields_q[5:0] : fields_q[11:6];
    assign phase_end = (is_a && !special) ? S_B_DEC : S_DONE;

    dcpu_operand_classify u_classify (
        .field      (field),
        .needs_nw   (needs_nw),
        .needs_ld   (needs_ld),
        .uses_reg   (uses_reg),
        .sp_predec  (sp_predec),
        .sp_postinc (sp_postinc),
        .is_literal (is_literal),
        .dst_kind   (dst_kind)
    );

    always_comb begin
        state_d   = state_q;
        fields_d  = fields_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        o_d       = o_q;
        a_val_d   = a_val;
        b_val_d   = b_val;
        a_dst_d   = a_dst;
        a_idx_d   = a_idx;
        a_addr_d  = a_addr;
        special_d = special;
        mem_re    = 1'b0;
        memaddr   = '0;
        reg_sel   = '0;
        val       = '0;
        val_en    = 1'b0;
        addr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fields_d  = ir[15:4];
                    pc_d      = pc_in;
                    sp_d      = sp_in;
                    o_d       = o_in;
                    special_d = (ir[3:0] == 4'h0);
                    a_val_d   = '0;
                    b_val_d   = '0;
                    a_dst_d   = DST_NONE;
                    a_idx_d   = '0;
                    a_addr_d  = '0;
                    state_d   = S_A_DEC;
                end
            end
            S_A_DEC, S_B_DEC: begin
                if (uses_reg) reg_sel = field[2:0];
                if (!needs_nw && !needs_ld) begin
                    val_en = 1'b1;
                    if (is_literal)          val = DWIDTH'(field[4:0]);
                    else if (uses_reg)       val = reg_rdata;
                    else if (field == F_SP)  val = DWIDTH'(sp_q);
                    else if (field == F_PC)  val = DWIDTH'(pc_q);
                    else                     val = o_q;
                    state_d = phase_end;
                end else if (needs_nw) begin
                    mem_re  = 1'b1;
                    memaddr = pc_q;
                    pc_d    = pc_q + ADDR_ONE;
                    state_d = is_a ? S_A_NW : S_B_NW;
                end else begin
                    mem_re  = 1'b1;
                    addr_en = 1'b1;
                    if (uses_reg)       memaddr = reg_rdata[AW1-1:0];
                    else if (sp_predec) memaddr = sp_q - ADDR_ONE;
                    else                memaddr = sp_q;
                    if (sp_predec)  sp_d = sp_q - ADDR_ONE;
                    if (sp_postinc) sp_d = sp_q + ADDR_ONE;
                    state_d = is_a ? S_A_LD : S_B_LD;
                end
                if (is_a) begin
                    a_dst_d = dst_kind;
                    if (uses_reg)                     a_idx_d = field[2:0];
                    else if (dst_kind == DST_SPECIAL) a_idx_d = special_idx(field);
                    else                              a_idx_d = 3'd0;
                end
            end
            S_A_NW, S_B_NW: begin
                if (uses_reg) reg_sel = field[2:0];
                if (is_literal) begin
                    val_en  = 1'b1;
                    val     = rmemdata;
                    state_d = phase_end;
                end else begin
                    mem_re  = 1'b1;
                    addr_en = 1'b1;
                    memaddr = rmemdata[AW1-1:0] + (uses_reg ? reg_rdata[AW1-1:0] : '0);
                    state_d = is_a ? S_A_LD : S_B_LD;
                end
            end
            S_A_LD, S_B_LD: begin
                val_en  = 1'b1;
                val     = rmemdata;
                state_d = phase_end;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (val_en) begin
            if (is_a) a_val_d = val;
            else      b_val_d = val;
        end
        if (addr_en && is_a) a_addr_d = memaddr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fields_q <= '0;
            pc_q     <= '0;
            sp_q     <= '0;
            o_q      <= '0;
            a_val    <= '0;
            b_val    <= '0;
            a_dst    <= DST_NONE;
            a_idx    <= '0;
            a_addr   <= '0;
            special  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fields_q <= fields_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            o_q      <= o_d;
            a_val    <= a_val_d;
            b_val    <= b_val_d;
            a_dst    <= a_dst_d;
            a_idx    <= a_idx_d;
            a_addr   <= a_addr_d;
            special  <= special_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign pc_out = pc_q;
    assign sp_out = sp_q;
    assign state  = state_q;

endmodule

// File: tb/tb_dcpu_operand_fetch.sv
// Directed bench for dcpu_operand_fetch with a register file and a one-cycle
// latency RAM model around the DUT.
module tb_dcpu_operand_fetch;
    import dcpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ir = '0;
    logic [14:0] pc_in = '0, sp_in = '0;
    logic [15:0] o_in = '0;
    logic [2:0]  reg_sel;
    logic [15:0] reg_rdata;
    logic        mem_re;
    logic [14:0] memaddr;
    logic [15:0] rmemdata = '0;
    logic        busy, done;
    logic [15:0] a_val, b_val;
    logic [1:0]  a_dst;
    logic [2:0]  a_idx;
    logic [14:0] a_addr, pc_out, sp_out;
    logic        special;
    state_t      state;

    logic [15:0] regs [8];
    logic [15:0] mem [0:32767];
    int n_cmp = 0;
    int n_fail = 0;
    int mre_cnt = 0;

    dcpu_operand_fetch #(.AWIDTH(16), .DWIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir), .pc_in(pc_in), .sp_in(sp_in),
        .o_in(o_in), .reg_sel(reg_sel), .reg_rdata(reg_rdata), .mem_re(mem_re),
        .memaddr(memaddr), .rmemdata(rmemdata), .busy(busy), .done(done),
        .a_val(a_val), .b_val(b_val), .a_dst(a_dst), .a_idx(a_idx), .a_addr(a_addr),
        .pc_out(pc_out), .sp_out(sp_out), .special(special), .state(state)
    );

    // clock / environment
    always #5 clk = ~clk;
    assign reg_rdata = regs[reg_sel];
    always @(posedge clk) rmemdata <= mem[memaddr];
    always @(negedge clk) if (mem_re) mre_cnt++;

    // Launch one instruction from an IDLE cycle; returns the cycle index of done.
    task automatic run_op(input logic [15:0] ir_v, input logic [14:0] pc_v,
                          input logic [14:0] sp_v, input logic [15:0] o_v, output int cyc);
        ir = ir_v; pc_in = pc_v; sp_in = sp_v; o_in = o_v; start = 1'b1;
        mre_cnt = 0;
        @(posedge clk); #1 start = 1'b0; ir = 16'hFFFF;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(posedge clk); #1 cyc++;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (mem_re !== 1'b0 || memaddr !== 15'h0) begin n_fail++; $display("FAIL reset_bus: got re=%b addr=%h want 0/0", mem_re, memaddr); end
        n_cmp++; if ({a_val, b_val} !== 32'h0) begin n_fail++; $display("FAIL reset_vals: got %h/%h want 0/0", a_val, b_val); end
        n_cmp++; if ({a_dst, a_idx, a_addr, special} !== 21'h0) begin n_fail++; $display("FAIL reset_desc: got %h/%h/%h/%b want 0", a_dst, a_idx, a_addr, special); end
        n_cmp++; if ({pc_out, sp_out} !== 30'h0) begin n_fail++; $display("FAIL reset_pcsp: got %h/%h want 0/0", pc_out, sp_out); end
        n_cmp++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
    endtask

    task automatic test_reg_reg;
        int cyc;
        regs[0] = 16'h1234; regs[1] = 16'h5678;
        run_op(16'h0401, 15'h0040, 15'h0100, 16'h0000, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL rr_cycle: got %0d want 3", cyc); end
        n_cmp++; if (a_val !== 16'h1234) begin n_fail++; $display("FAIL rr_a_val: got %h want 1234", a_val); end
        n_cmp++; if (b_val !== 16'h5678) begin n_fail++; $display("FAIL rr_b_val: got %h want 5678", b_val); end
        n_cmp++; if (a_dst !== DST_REG || a_idx !== 3'd0) begin n_fail++; $display("FAIL rr_dst: got %0d/%0d want 1/0", a_dst, a_idx); end
        n_cmp++; if (mre_cnt !== 0) begin n_fail++; $display("FAIL rr_mem_re: got %0d reads want 0", mre_cnt); end
        n_cmp++; if (pc_out !== 15'h0040 || special !== 1'b0) begin n_fail++; $display("FAIL rr_pc: got %h/%b want 0040/0", pc_out, special); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rr_after_done: got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_next_word;
        int cyc;
        mem[15'h0010] = 16'h1000; mem[15'h1000] = 16'hBEEF; mem[15'h0011] = 16'h0042;
        run_op(16'h7DE1, 15'h0010, 15'h0200, 16'h0000, cyc);
        n_cmp++; if (cyc !== 6) begin n_fail++; $display("FAIL nw_cycle: got %0d want 6", cyc); end
        n_cmp++; if (a_addr !== 15'h1000 || a_dst !== DST_MEM) begin n_fail++; $display("FAIL nw_a_addr: got %h/%0d want 1000/2", a_addr, a_dst); end
        n_cmp++; if (a_val !== 16'hBEEF) begin n_fail++; $display("FAIL nw_a_val: got %h want beef", a_val); end
        n_cmp++; if (b_val !== 16'h0042) begin n_fail++; $display("FAIL nw_b_val: got %h want 0042", b_val); end
        n_cmp++; if (pc_out !== 15'h0012) begin n_fail++; $display("FAIL nw_pc_out: got %h want 0012", pc_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_push_wrap;
        int cyc;
        mem[15'h7FFF] = 16'hA5A5;
        run_op(16'h95A1, 15'h0050, 15'h0000, 16'h0000, cyc);
        n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL push_cycle: got %0d want 4", cyc); end
        n_cmp++; if (sp_out !== 15'h7FFF) begin n_fail++; $display("FAIL push_sp_out: got %h want 7fff", sp_out); end
        n_cmp++; if (a_dst !== DST_MEM || a_addr !== 15'h7FFF) begin n_fail++; $display("FAIL push_dst: got %0d/%h want 2/7fff", a_dst, a_addr); end
        n_cmp++; if (a_val !== 16'hA5A5 || b_val !== 16'h0005) begin n_fail++; $display("FAIL push_vals: got %h/%h want a5a5/0005", a_val, b_val); end
        @(posedge clk); #1;
    endtask

    task automatic test_indexed_nw;
        int cyc;
        regs[0] = 16'h0AAA; regs[1] = 16'h0005;
        mem[15'h0020] = 16'h0100; mem[15'h0105] = 16'hCAFE;
        run_op(16'h4401, 15'h0020, 15'h0300, 16'h0000, cyc);
        n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL idx_cycle: got %0d want 5", cyc); end
        n_cmp++; if (b_val !== 16'hCAFE || a_val !== 16'h0AAA) begin n_fail++; $display("FAIL idx_vals: got %h/%h want 0aaa/cafe", a_val, b_val); end
        n_cmp++; if (pc_out !== 15'h0021) begin n_fail++; $display("FAIL idx_pc_out: got %h want 0021", pc_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_special;
        int cyc;
        mem[15'h0060] = 16'h0200;
        run_op(16'h7C10, 15'h0060, 15'h0400, 16'h0000, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL spc_cycle: got %0d want 3", cyc); end
        n_cmp++; if (special !== 1'b1) begin n_fail++; $display("FAIL spc_flag: got %b want 1", special); end
        n_cmp++; if (a_val !== 16'h0200 || b_val !== 16'h0000) begin n_fail++; $display("FAIL spc_vals: got %h/%h want 0200/0000", a_val, b_val); end
        n_cmp++; if (a_dst !== DST_NONE || pc_out !== 15'h0061) begin n_fail++; $display("FAIL spc_dst: got %0d/%h want 0/0061", a_dst, pc_out); end
        @(posedge clk); #1;
    endtask

    // POP then SP value: b must observe the post-incremented SP from a.
    task automatic test_pop_then_sp;
        int cyc;
        mem[15'h0100] = 16'h7777;
        run_op(16'h6D81, 15'h0070, 15'h0100, 16'h0000, cyc);
        n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL pop_cycle: got %0d want 4", cyc); end
        n_cmp++; if (a_val !== 16'h7777 || a_addr !== 15'h0100) begin n_fail++; $display("FAIL pop_a: got %h/%h want 7777/0100", a_val, a_addr); end
        n_cmp++; if (b_val !== 16'h0101 || sp_out !== 15'h0101) begin n_fail++; $display("FAIL pop_b_sp: got %h/%h want 0101/0101", b_val, sp_out); end
        @(posedge clk); #1;
    endtask

    // start held while busy with a different ir must not disturb the running op.
    task automatic test_start_ignored;
        int cyc;
        regs[0] = 16'h1111; regs[1] = 16'h2222;
        ir = 16'h0401; pc_in = 15'h0005; sp_in = 15'h0009; o_in = 16'h0; start = 1'b1;
        @(posedge clk); #1 ir = 16'h95A1; pc_in = 15'h0777;
        cyc = 1;
        @(posedge clk); #1 start = 1'b0; cyc++;
        while (!done && cyc < 20) begin
            @(posedge clk); #1 cyc++;
        end
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL ign_cycle: got %0d want 3", cyc); end
        n_cmp++; if (a_val !== 16'h1111 || b_val !== 16'h2222 || pc_out !== 15'h0005) begin n_fail++; $display("FAIL ign_vals: got %h/%h/%h want 1111/2222/0005", a_val, b_val, pc_out); end
        @(posedge clk); #1;
        n_cmp++; if (state !== S_IDLE) begin n_fail++; $display("FAIL ign_idle: got %0d want %0d", state, S_IDLE); end
    endtask

    task automatic test_reset_mid_op;
        int cyc;
        mem[15'h0010] = 16'h1000;
        ir = 16'h7DE1; pc_in = 15'h0010; sp_in = 15'h0010; o_in = 16'h0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (state !== S_A_NW) begin n_fail++; $display("FAIL rst_pre_state: got %0d want %0d", state, S_A_NW); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outs: got busy=%b done=%b re=%b want 0/0/0", busy, done, mem_re); end
        n_cmp++; if (state !== S_IDLE || pc_out !== 15'h0) begin n_fail++; $display("FAIL rst_mid_state: got %0d/%h want %0d/0000", state, pc_out, S_IDLE); end
        mem[15'h0030] = 16'h2000; mem[15'h2000] = 16'h1111;
        mem[15'h0031] = 16'h3000; mem[15'h3000] = 16'h2222;
        run_op(16'h79E1, 15'h0030, 15'h0010, 16'h0000, cyc);
        n_cmp++; if (cyc !== 7) begin n_fail++; $display("FAIL worst_cycle: got %0d want 7", cyc); end
        n_cmp++; if (a_val !== 16'h1111 || b_val !== 16'h2222 || a_addr !== 15'h2000) begin n_fail++; $display("FAIL worst_vals: got %h/%h/%h want 1111/2222/2000", a_val, b_val, a_addr); end
        n_cmp++; if (pc_out !== 15'h0032) begin n_fail++; $display("FAIL worst_pc_out: got %h want 0032", pc_out); end
        @(posedge clk); #1;
    endtask

    // Second instruction launched in the cycle right after DONE.
    task automatic test_back_to_back;
        int cyc;
        regs[2] = 16'h00AB; regs[3] = 16'h00CD;
        run_op(16'h0C21, 15'h0001, 15'h0002, 16'h0000, cyc);
        n_cmp++; if (cyc !== 3 || a_val !== 16'h00AB || b_val !== 16'h00CD) begin n_fail++; $display("FAIL b2b_first: got cyc=%0d %h/%h want 3 00ab/00cd", cyc, a_val, b_val); end
        @(posedge clk); #1;
        run_op(16'h71D1, 15'h0001, 15'h0002, 16'h9876, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL b2b_cycle: got %0d want 3", cyc); end
        n_cmp++; if (a_val !== 16'h9876 || b_val !== 16'h0001) begin n_fail++; $display("FAIL b2b_vals: got %h/%h want 9876/0001", a_val, b_val); end
        n_cmp++; if (a_dst !== DST_SPECIAL || a_idx !== IDX_O) begin n_fail++; $display("FAIL b2b_dst: got %0d/%0d want 3/2", a_dst, a_idx); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_reg_reg;
        test_next_word;
        test_push_wrap;
        test_indexed_nw;
        test_special;
        test_pop_then_sp;
        test_start_ignored;
        test_reset_mid_op;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
